// File: rtl/game_pkg.sv
// Types shared by the move-capture front end and the tic-tac-toe game FSM.
package game_pkg;

    localparam int unsigned NUM_SQUARES = 9;

    typedef logic [NUM_SQUARES-1:0] move_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        CHECK,
        OFFER,
        DEB_RELEASE
    } capture_state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input move_t v);
        return (v != '0) && ((v & (v - move_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/move_capture.sv
// Debounces the submit button, validates the selected square and offers it to the game FSM.
// Define MOVE_CAPTURE_SYNC_EN to pass btn and sw through two-flop synchronizers first.
module move_capture
    import game_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SQUARES-1:0] sw,
    input  logic                   btn,
    input  logic [NUM_SQUARES-1:0] occupied,
    input  logic                   new_game,
    input  logic                   move_ready,
    output logic                   move_valid,
    output logic [NUM_SQUARES-1:0] move,
    output logic                   move_reject,
    output logic                   player
);

    localparam int unsigned CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic           btn_s;
    move_t          sw_s;

    capture_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    move_t          move_q, move_d;
    logic           valid_q, valid_d;
    logic           reject_q, reject_d;
    player_t        player_q, player_d;

`ifdef MOVE_CAPTURE_SYNC_EN
    sync2 #(.W(1)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

    sync2 #(.W(NUM_SQUARES)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );
`else
    assign btn_s = btn;
    assign sw_s  = sw;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            move_q   <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            player_q <= P1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            move_q   <= move_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
            player_q <= player_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        move_d   = move_q;
        valid_d  = valid_q;
        reject_d = 1'b0;
        player_d = player_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) begin
                    cnt_d   = CW'(1);
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (is_onehot(sw_s) && ((sw_s & occupied) == '0)) begin
                    move_d  = sw_s;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else begin
                    reject_d = 1'b1;
                    state_d  = DEB_RELEASE;
                end
            end
            OFFER: begin
                if (valid_q && move_ready) begin
                    player_d = (player_q == P1) ? P2 : P1;
                    move_d   = '0;
                    valid_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                // Count is the number of consecutive low samples seen so far, minus one.
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // New game clears the turn and withdraws any pending offer.
        if (new_game) begin
            player_d = P1;
            if (state_q == OFFER) begin
                move_d  = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = DEB_RELEASE;
            end
        end
    end

    assign move_valid  = valid_q;
    assign move        = move_q;
    assign move_reject = reject_q;
    assign player      = player_q;

endmodule

// File: tb/tb_move_capture.sv
// Self-checking bench for move_capture: run-length reference model plus directed literal checks.
module tb_move_capture;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] sw;
    logic       btn;
    logic [8:0] occupied;
    logic       new_game;
    logic       move_ready;
    logic       move_valid;
    logic [8:0] move;
    logic       move_reject;
    logic       player;

    int total = 0;
    int bad   = 0;

    move_capture #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn         (btn),
        .occupied    (occupied),
        .new_game    (new_game),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move        (move),
        .move_reject (move_reject),
        .player      (player)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: a press is confirmed after DB consecutive high samples, the board is
    // judged one sample later, and a new press is only armed after DB consecutive low samples.
    bit         m_live = 0;
    bit         m_check, m_offer, m_rel, m_reject, m_player;
    int         m_high, m_low;
    logic [8:0] m_move;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_check = 0; m_offer = 0; m_rel = 0; m_reject = 0; m_player = 0;
            m_high = 0; m_low = 0; m_move = '0;
        end else if (m_live) begin
            m_reject = 0;
            if (m_check) begin
                m_check = 0;
                if ($countones(sw) == 1 && (sw & occupied) == 9'h000) begin
                    m_offer = 1;
                    m_move  = sw;
                end else begin
                    m_reject = 1;
                    m_rel    = 1;
                    m_low    = 0;
                end
            end else if (m_offer) begin
                if (new_game || move_ready) begin
                    m_offer = 0;
                    m_rel   = 1;
                    m_low   = 0;
                    if (!new_game) m_player = ~m_player;
                end
            end else if (m_rel) begin
                m_low = btn ? 0 : m_low + 1;
                if (m_low == DB) m_rel = 0;
            end else begin
                m_high = btn ? m_high + 1 : 0;
                if (m_high == DB) begin
                    m_check = 1;
                    m_high  = 0;
                end
            end
            if (new_game) m_player = 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid",  32'(move_valid),  32'(m_offer));
            chk("model_move",   32'(move),        32'(m_offer ? m_move : 9'h000));
            chk("model_reject", 32'(move_reject), 32'(m_reject));
            chk("model_player", 32'(player),      32'(m_player));
        end
    end

    logic [8:0] pat_sw  [3] = '{9'h003, 9'h000, 9'h001};
    logic [8:0] pat_occ [3] = '{9'h000, 9'h000, 9'h001};

    initial begin
        rst = 1'b1; sw = '0; btn = 1'b0; occupied = '0; new_game = 1'b0; move_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("reset_valid",  32'(move_valid),  32'd0);
        chk("reset_move",   32'(move),        32'd0);
        chk("reset_reject", 32'(move_reject), 32'd0);
        chk("reset_player", 32'(player),      32'd0);

        // Basic legal move with immediate acceptance.
        sw = 9'h010; move_ready = 1'b1; btn = 1'b1;
        tick(4);
        chk("t1_not_yet", 32'(move_valid), 32'd0);
        tick(1);
        chk("t1_valid", 32'(move_valid), 32'd1);
        chk("t1_move",  32'(move),       32'h010);
        chk("t1_player_before", 32'(player), 32'd0);
        tick(1);
        chk("t1_valid_drop", 32'(move_valid), 32'd0);
        chk("t1_player_after", 32'(player), 32'd1);
        tick(4);
        btn = 1'b0;
        tick(6);

        // Press one sample too short.
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(5);
        chk("t2_valid",  32'(move_valid),  32'd0);
        chk("t2_reject", 32'(move_reject), 32'd0);

        // Illegal selections.
        for (int i = 0; i < 3; i++) begin
            sw = pat_sw[i]; occupied = pat_occ[i]; btn = 1'b1;
            tick(5);
            chk("t3_reject", 32'(move_reject), 32'd1);
            chk("t3_valid",  32'(move_valid),  32'd0);
            tick(1);
            chk("t3_reject_pulse", 32'(move_reject), 32'd0);
            chk("t3_player", 32'(player), 32'd1);
            btn = 1'b0;
            tick(6);
        end

        // Stalled offer with noisy inputs.
        sw = 9'h100; occupied = 9'h000; move_ready = 1'b0; btn = 1'b1;
        tick(5);
        chk("t4_valid", 32'(move_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            sw = 9'($urandom); btn = 1'($urandom); occupied = 9'($urandom);
            tick(1);
            chk("t4_hold", 32'(move), 32'h100);
        end
        move_ready = 1'b1; btn = 1'b1; occupied = 9'h000;
        tick(1);
        chk("t4_valid_drop", 32'(move_valid), 32'd0);
        chk("t4_player", 32'(player), 32'd0);

        // Held button gives no second offer; release must be uninterrupted.
        tick(100);
        chk("t5_no_repeat", 32'(move_valid), 32'd0);
        btn = 1'b0; tick(3);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(4);
        sw = 9'h004; btn = 1'b1;
        tick(5);
        chk("t5_valid", 32'(move_valid), 32'd1);
        chk("t5_move",  32'(move),       32'h004);
        tick(1);
        chk("t5_player", 32'(player), 32'd1);
        btn = 1'b0;
        tick(6);

        // New game withdraws an offer.
        sw = 9'h001; occupied = 9'h0f0; move_ready = 1'b0; btn = 1'b1;
        tick(5);
        chk("t6_valid", 32'(move_valid), 32'd1);
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        chk("t6_withdrawn", 32'(move_valid), 32'd0);
        chk("t6_player",    32'(player),     32'd0);
        btn = 1'b0;
        tick(6);

        // Accept one move, then reset in the middle of a press.
        sw = 9'h002; occupied = 9'h000; move_ready = 1'b1; btn = 1'b1;
        tick(6);
        chk("t7_player", 32'(player), 32'd1);
        btn = 1'b0;
        tick(6);
        btn = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; btn = 1'b0;
        chk("t7_rst_valid",  32'(move_valid),  32'd0);
        chk("t7_rst_move",   32'(move),        32'd0);
        chk("t7_rst_reject", 32'(move_reject), 32'd0);
        chk("t7_rst_player", 32'(player),      32'd0);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
